// File: rtl/corefifo_fwft_prefetch_if.sv
// Signal bundle between the FWFT prefetch stage, the FIFO controller/RAM and the read-side user.
// The master modport is the prefetch stage itself; the slave modport is its environment.
interface corefifo_fwft_prefetch_if #(
    parameter int RWIDTH   = 10,
    parameter int PF_DEPTH = 4
);
    localparam int CW = $clog2(PF_DEPTH + 1);

    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [RWIDTH-1:0] fifo_dout;
    logic              flush;
    logic              rd_en;
    logic [RWIDTH-1:0] dout;
    logic              empty;
    logic              aempty;
    logic              dvld;
    logic [CW-1:0]     occupancy;
    logic              underflow;

    modport master (
        input  fifo_empty, fifo_dout, flush, rd_en,
        output fifo_rd_en, dout, empty, aempty, dvld, occupancy, underflow
    );

    modport slave (
        output fifo_empty, fifo_dout, flush, rd_en,
        input  fifo_rd_en, dout, empty, aempty, dvld, occupancy, underflow
    );
endinterface

// File: rtl/corefifo_fwft_prefetch.sv
// First-word-fall-through read stage: reads the FIFO RAM ahead of demand into a small
// prefetch buffer so the head word is always presented, hiding a RAM latency of 1..3 cycles.
module corefifo_fwft_prefetch #(
    parameter int RWIDTH        = 10,
    parameter int RAM_LAT       = 1,
    parameter int PF_DEPTH      = 4,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                         clk,
    input  logic                         reset_rclk,
    corefifo_fwft_prefetch_if.master     bus
);
    localparam int CW = $clog2(PF_DEPTH + 1);
    localparam int PW = $clog2(PF_DEPTH);

    logic [RWIDTH-1:0] mem [PF_DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     occ_q;
    logic [CW-1:0]     inflight_q;
    logic [RAM_LAT-1:0] pipe;
    logic              empty_q;
    logic              aempty_q;
    logic              underflow_q;

    logic              pop;
    logic              ret_wr;
    logic              issue;
    logic [CW:0]       credit;
    logic [CW-1:0]     occ_next;
    logic [CW-1:0]     inflight_next;

    // Credit counts buffered plus in-flight words, so a read is only issued when a slot is
    // guaranteed free on return; this is what makes buffer overflow impossible.
    always_comb begin
        pop           = bus.rd_en & ~empty_q;
        ret_wr        = pipe[RAM_LAT-1];
        credit        = {1'b0, occ_q} + {1'b0, inflight_q} - (CW+1)'(pop);
        issue         = ~bus.fifo_empty & ~bus.flush & (credit < (CW+1)'(PF_DEPTH));
        occ_next      = occ_q + CW'(ret_wr) - CW'(pop);
        inflight_next = inflight_q + CW'(issue) - CW'(ret_wr);
    end

    always_ff @(posedge clk or posedge reset_rclk) begin
        if (reset_rclk) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            occ_q       <= '0;
            inflight_q  <= '0;
            pipe        <= '0;
            empty_q     <= 1'b1;
            aempty_q    <= 1'b1;
            underflow_q <= 1'b0;
            for (int i = 0; i < PF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.flush) begin
            // Late returns are dropped simply by clearing their valid bits in the return pipe.
            rd_ptr      <= wr_ptr;
            occ_q       <= '0;
            inflight_q  <= '0;
            pipe        <= '0;
            empty_q     <= 1'b1;
            aempty_q    <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            pipe[0] <= issue;
            for (int i = 1; i < RAM_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
            if (ret_wr) begin
                mem[wr_ptr] <= bus.fifo_dout;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            occ_q       <= occ_next;
            inflight_q  <= inflight_next;
            empty_q     <= (occ_next == '0);
            aempty_q    <= (occ_next <= CW'(AEMPTY_THRESH));
            underflow_q <= bus.rd_en & empty_q;
        end
    end

    assign bus.fifo_rd_en = issue;
    assign bus.dout       = mem[rd_ptr];
    assign bus.empty      = empty_q;
    assign bus.aempty     = aempty_q;
    assign bus.dvld       = ~empty_q;
    assign bus.occupancy  = occ_q;
    assign bus.underflow  = underflow_q;
endmodule

// File: tb/tb_corefifo_fwft_prefetch.sv
// Directed bench for corefifo_fwft_prefetch with a behavioural controller/RAM source and a
// scoreboard monitor that checks every popped head word against the expected stream.
module tb_corefifo_fwft_prefetch;
    localparam int RWIDTH        = 10;
    localparam int RAM_LAT       = 3;
    localparam int PF_DEPTH      = 4;
    localparam int AEMPTY_THRESH = 1;

    logic clk        = 1'b0;
    logic reset_rclk = 1'b1;
    logic hold_empty = 1'b0;

    corefifo_fwft_prefetch_if #(.RWIDTH(RWIDTH), .PF_DEPTH(PF_DEPTH)) bus ();

    corefifo_fwft_prefetch #(
        .RWIDTH(RWIDTH),
        .RAM_LAT(RAM_LAT),
        .PF_DEPTH(PF_DEPTH),
        .AEMPTY_THRESH(AEMPTY_THRESH)
    ) dut (
        .clk(clk),
        .reset_rclk(reset_rclk),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [RWIDTH-1:0] src_mem [512];
    logic [RWIDTH-1:0] ram_stage [RAM_LAT];
    int src_wr = 0;
    int src_rd = 0;

    // Controller/RAM model: shares the read-side reset, so words in flight at reset are lost.
    assign bus.fifo_empty = hold_empty || (src_rd == src_wr);
    assign bus.fifo_dout  = ram_stage[RAM_LAT-1];

    always @(posedge clk or posedge reset_rclk) begin
        if (reset_rclk) begin
            src_rd <= src_wr;
            for (int i = 0; i < RAM_LAT; i++) ram_stage[i] <= '0;
        end else begin
            ram_stage[0] <= bus.fifo_rd_en ? src_mem[src_rd] : '0;
            for (int i = 1; i < RAM_LAT; i++) ram_stage[i] <= ram_stage[i-1];
            if (bus.fifo_rd_en) src_rd <= src_rd + 1;
        end
    end

    logic [RWIDTH-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: a pop happens at the next rising edge whenever dvld and rd_en are high outside flush.
    always @(negedge clk) begin
        if (!reset_rclk && bus.dvld && bus.rd_en && !bus.flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pop: got 0x%0h, expected no word", bus.dout);
            end else begin
                check_output("scoreboard_dout", int'(bus.dout), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            src_mem[src_wr + i] = RWIDTH'(base + i);
            exp_q.push_back(RWIDTH'(base + i));
        end
        src_wr = src_wr + n;
    endtask

    task automatic wait_dvld(input int budget, output int waited);
        waited = 0;
        sample();
        while (!bus.dvld && waited < budget) begin
            tick();
            sample();
            waited++;
        end
        check_output("first_word_dvld", int'(bus.dvld), 1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        tick();
        bus.rd_en = 1'b1;
        sample();
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            sample();
            n++;
        end
        tick();
        bus.rd_en = 1'b0;
        check_output("drain_complete", exp_q.size(), 0);
    endtask

    initial begin
        int waited;
        int bubbles;
        int issued;
        int max_occ;

        bus.flush = 1'b0;
        bus.rd_en = 1'b0;
        repeat (3) @(posedge clk);
        sample();
        check_output("reset_empty", int'(bus.empty), 1);
        check_output("reset_aempty", int'(bus.aempty), 1);
        check_output("reset_occupancy", int'(bus.occupancy), 0);
        check_output("reset_dout", int'(bus.dout), 0);
        check_output("reset_underflow", int'(bus.underflow), 0);
        #2 reset_rclk = 1'b0;

        $display("[TB] single word latency");
        tick();
        apply_stimulus(1, 'h155);
        sample();
        check_output("t1_fifo_rd_en", int'(bus.fifo_rd_en), 1);
        for (int c = 1; c <= RAM_LAT; c++) begin
            tick();
            sample();
            check_output("t1_priming_empty", int'(bus.empty), 1);
        end
        tick();
        sample();
        check_output("t1_empty", int'(bus.empty), 0);
        check_output("t1_dout", int'(bus.dout), 'h155);
        check_output("t1_occupancy", int'(bus.occupancy), 1);
        tick();
        bus.rd_en = 1'b1;
        sample();
        tick();
        bus.rd_en = 1'b0;
        sample();
        check_output("t1_empty_after_pop", int'(bus.empty), 1);
        check_output("t1_occupancy_after_pop", int'(bus.occupancy), 0);

        $display("[TB] 64 word stream");
        tick();
        bus.rd_en = 1'b1;
        apply_stimulus(64, 0);
        wait_dvld(20, waited);
        check_output("t2_first_word_latency", waited, RAM_LAT + 1);
        bubbles = 0;
        for (int k = 1; k < 64; k++) begin
            tick();
            sample();
            if (!bus.dvld) bubbles++;
        end
        check_output("t2_bubbles", bubbles, 0);
        tick();
        sample();
        check_output("t2_empty_at_end", int'(bus.empty), 1);
        tick();
        bus.rd_en = 1'b0;
        sample();
        check_output("t2_underflow_pulse", int'(bus.underflow), 1);
        tick();
        sample();
        check_output("t2_underflow_clear", int'(bus.underflow), 0);

        $display("[TB] credit limit");
        tick();
        apply_stimulus(10, 'h200);
        issued  = 0;
        max_occ = 0;
        for (int c = 0; c < 12; c++) begin
            sample();
            if (bus.fifo_rd_en) issued++;
            if (int'(bus.occupancy) > max_occ) max_occ = int'(bus.occupancy);
            tick();
        end
        sample();
        check_output("t3_reads_issued", issued, PF_DEPTH);
        check_output("t3_occupancy", int'(bus.occupancy), PF_DEPTH);
        check_output("t3_max_occupancy", max_occ, PF_DEPTH);
        check_output("t3_aempty", int'(bus.aempty), 0);
        check_output("t3_dout", int'(bus.dout), 'h200);

        $display("[TB] almost-empty and underflow");
        tick();
        hold_empty = 1'b1;
        for (int k = PF_DEPTH - 1; k >= 0; k--) begin
            bus.rd_en = 1'b1;
            sample();
            tick();
            bus.rd_en = 1'b0;
            sample();
            check_output("t4_occupancy", int'(bus.occupancy), k);
            check_output("t4_aempty", int'(bus.aempty), (k <= AEMPTY_THRESH) ? 1 : 0);
            check_output("t4_empty", int'(bus.empty), (k == 0) ? 1 : 0);
            tick();
        end
        bus.rd_en = 1'b1;
        sample();
        check_output("t4_underflow_before", int'(bus.underflow), 0);
        tick();
        bus.rd_en = 1'b0;
        sample();
        check_output("t4_underflow_pulse", int'(bus.underflow), 1);
        check_output("t4_occupancy_unchanged", int'(bus.occupancy), 0);
        tick();
        sample();
        check_output("t4_underflow_one_cycle", int'(bus.underflow), 0);

        // Two reads land in the buffer, two more are in flight when flush hits.
        $display("[TB] flush with buffered and in-flight words");
        tick();
        hold_empty = 1'b0;
        tick();
        tick();
        hold_empty = 1'b1;
        repeat (3) tick();
        hold_empty = 1'b0;
        sample();
        check_output("t5_occupancy_before", int'(bus.occupancy), 2);
        tick();
        tick();
        bus.flush = 1'b1;
        bus.rd_en = 1'b1;
        repeat (4) void'(exp_q.pop_front());
        sample();
        check_output("t5_flush_blocks_read", int'(bus.fifo_rd_en), 0);
        tick();
        bus.flush = 1'b0;
        bus.rd_en = 1'b0;
        sample();
        check_output("t5_empty_after_flush", int'(bus.empty), 1);
        check_output("t5_occupancy_after_flush", int'(bus.occupancy), 0);
        check_output("t5_no_underflow", int'(bus.underflow), 0);
        repeat (3) tick();
        sample();
        check_output("t5_late_returns_dropped", int'(bus.occupancy), 0);
        tick();
        sample();
        check_output("t5_next_word_empty", int'(bus.empty), 0);
        check_output("t5_next_word_dout", int'(bus.dout), 'h208);
        drain(20);

        $display("[TB] asynchronous reset mid-stream");
        tick();
        bus.rd_en = 1'b1;
        apply_stimulus(8, 'h300);
        wait_dvld(20, waited);
        tick();
        tick();
        @(negedge clk);
        #2 reset_rclk = 1'b1;
        exp_q.delete();
        #1;
        check_output("t6_reset_empty", int'(bus.empty), 1);
        check_output("t6_reset_dvld", int'(bus.dvld), 0);
        check_output("t6_reset_occupancy", int'(bus.occupancy), 0);
        check_output("t6_reset_aempty", int'(bus.aempty), 1);
        check_output("t6_reset_dout", int'(bus.dout), 0);
        bus.rd_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2 reset_rclk = 1'b0;
        tick();
        apply_stimulus(3, 'h3C0);
        sample();
        check_output("t6_fifo_rd_en", int'(bus.fifo_rd_en), 1);
        for (int c = 1; c <= RAM_LAT; c++) begin
            tick();
            sample();
            check_output("t6_priming_empty", int'(bus.empty), 1);
        end
        tick();
        sample();
        check_output("t6_first_empty", int'(bus.empty), 0);
        check_output("t6_first_dout", int'(bus.dout), 'h3C0);
        drain(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
